// File: rtl/pid_pkg.sv
// Shared definitions for the fixed-point PID datapath.
// Default widths and the signed single/double-width data types.
package pid_pkg;

    localparam int N_DEF    = 18;
    localparam int FRAC_DEF = 8;

    typedef logic signed [N_DEF-1:0]   dato_t;
    typedef logic signed [2*N_DEF-1:0] dato2_t;

endpackage

// File: rtl/sumador_saturado.sv
// Combinational accumulator adder with two-sided clamp for the integral term.
// The sum is formed one bit wider than the accumulator so it can never wrap.
module sumador_saturado
    import pid_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic [2*N-1:0] acc_i,
    input  logic [2*N-1:0] p_i,
    input  logic [N-1:0]   lim_hi_i,
    input  logic [N-1:0]   lim_lo_i,
    output logic [2*N-1:0] res_o,
    output logic           sat_o
);

    logic signed [2*N:0] sum;
    logic signed [2*N:0] hi;
    logic signed [2*N:0] lo;
    logic signed [2*N:0] c1;
    logic                sat_hi;
    logic                sat_lo;

    always_comb begin
        sum = $signed({acc_i[2*N-1], acc_i}) + $signed({p_i[2*N-1], p_i});
        hi  = $signed({{(N+1){lim_hi_i[N-1]}}, lim_hi_i}) <<< FRAC;
        lo  = $signed({{(N+1){lim_lo_i[N-1]}}, lim_lo_i}) <<< FRAC;

        // Upper clamp first, then lower, so an inverted pair resolves to LO.
        sat_hi = (sum > hi);
        c1     = sat_hi ? hi : sum;
        sat_lo = (c1 < lo);
        res_o  = sat_lo ? lo[2*N-1:0] : c1[2*N-1:0];
        sat_o  = sat_hi | sat_lo;
    end

endmodule

// File: rtl/integrador_pid.sv
// Integral term of the PID: ik = clamp(sum(ek*ki)) >> FRAC, three-stage pipeline.
// S1 registers the sample, S2 the product, S3 the clamped accumulator and outputs.
module integrador_pid
    import pid_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] ek,
    input  logic         ek_valid,
    input  logic [N-1:0] ki,
    input  logic [N-1:0] lim_hi,
    input  logic [N-1:0] lim_lo,
    input  logic         hold,
    input  logic         clear,
    output logic [N-1:0] ik,
    output logic         ik_valid,
    output logic         ik_sat
);

    logic [N-1:0]   ek_q, ek_d;
    logic [N-1:0]   ki_q, ki_d;
    logic           v1_q, v1_d;
    logic [2*N-1:0] p_q, p_d;
    logic           v2_q, v2_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   ik_q, ik_d;
    logic           ik_sat_q, ik_sat_d;
    logic           ik_valid_q, ik_valid_d;

    logic [2*N-1:0] clamped;
    logic           sat;

    sumador_saturado #(
        .N    (N),
        .FRAC (FRAC)
    ) u_sumador (
        .acc_i    (acc_q),
        .p_i      (p_q),
        .lim_hi_i (lim_hi),
        .lim_lo_i (lim_lo),
        .res_o    (clamped),
        .sat_o    (sat)
    );

    always_comb begin
        ek_d       = ek_q;
        ki_d       = ki_q;
        v1_d       = v1_q;
        p_d        = p_q;
        v2_d       = v2_q;
        acc_d      = acc_q;
        ik_d       = ik_q;
        ik_sat_d   = ik_sat_q;
        ik_valid_d = 1'b0;

        if (clear) begin
            v1_d     = 1'b0;
            v2_d     = 1'b0;
            acc_d    = '0;
            ik_d     = '0;
            ik_sat_d = 1'b0;
        end else begin
            v1_d = ek_valid;
            if (ek_valid) begin
                ek_d = ek;
                ki_d = ki;
            end
            v2_d = v1_q;
            // Operands sign-extended to 2N so the low 2N bits are the signed product.
            p_d  = $signed({{N{ek_q[N-1]}}, ek_q}) * $signed({{N{ki_q[N-1]}}, ki_q});
            ik_valid_d = v2_q;
            if (v2_q && !hold) begin
                acc_d    = clamped;
                ik_d     = clamped[FRAC+N-1:FRAC];
                ik_sat_d = sat;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ek_q       <= '0;
            ki_q       <= '0;
            v1_q       <= 1'b0;
            p_q        <= '0;
            v2_q       <= 1'b0;
            acc_q      <= '0;
            ik_q       <= '0;
            ik_sat_q   <= 1'b0;
            ik_valid_q <= 1'b0;
        end else begin
            ek_q       <= ek_d;
            ki_q       <= ki_d;
            v1_q       <= v1_d;
            p_q        <= p_d;
            v2_q       <= v2_d;
            acc_q      <= acc_d;
            ik_q       <= ik_d;
            ik_sat_q   <= ik_sat_d;
            ik_valid_q <= ik_valid_d;
        end
    end

    assign ik       = ik_q;
    assign ik_valid = ik_valid_q;
    assign ik_sat   = ik_sat_q;

endmodule

// File: tb/tb_integrador_pid.sv
// Bench for integrador_pid: directed scenarios plus random streaming against a
// sample-history reference model (each edge settles the sample accepted two edges earlier).
module tb_integrador_pid;

    localparam int N    = 18;
    localparam int FRAC = 8;
    localparam int MAXC = 4096;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] ek, ki, lim_hi, lim_lo, ik;
    logic         ek_valid, hold, clear;
    logic         ik_valid, ik_sat;

    integrador_pid #(
        .N    (N),
        .FRAC (FRAC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ek       (ek),
        .ek_valid (ek_valid),
        .ki       (ki),
        .lim_hi   (lim_hi),
        .lim_lo   (lim_lo),
        .hold     (hold),
        .clear    (clear),
        .ik       (ik),
        .ik_valid (ik_valid),
        .ik_sat   (ik_sat)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int vcnt     = 0;

    // Reference state: sample history by edge index plus the integral itself.
    int     cyc = 0;
    bit     sv  [MAXC];
    longint sek [MAXC];
    longint ski [MAXC];
    longint m_acc = 0;
    longint m_ik  = 0;
    bit     m_sat = 0;
    bit     m_valid = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_zero();
        m_acc   = 0;
        m_ik    = 0;
        m_sat   = 0;
        m_valid = 0;
    endtask

    task automatic model_edge();
        int     t;
        longint sum, hi, lo, c;
        bit     s;
        cyc++;
        t = cyc;
        if (t >= MAXC) begin
            $display("FAIL cycle_budget: got=%0d exp<%0d", t, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        if (reset) begin
            model_zero();
            sv[t] = 0;
        end else if (clear) begin
            model_zero();
            sv[t] = 0;
            if (t >= 1) sv[t-1] = 0;
            if (t >= 2) sv[t-2] = 0;
        end else begin
            sv[t]  = ek_valid;
            sek[t] = longint'($signed(ek));
            ski[t] = longint'($signed(ki));
            m_valid = (t >= 2) && sv[t-2];
            if (m_valid && !hold) begin
                sum = m_acc + sek[t-2] * ski[t-2];
                hi  = longint'($signed(lim_hi)) * (64'sd1 << FRAC);
                lo  = longint'($signed(lim_lo)) * (64'sd1 << FRAC);
                c   = sum;
                s   = 0;
                if (c > hi) begin c = hi; s = 1; end
                if (c < lo) begin c = lo; s = 1; end
                m_acc = c;
                m_ik  = c >>> FRAC;
                m_sat = s;
            end
        end
    endtask

    task automatic step(input bit v, input int e, input int k, input bit h, input bit c);
        @(negedge clk);
        ek_valid = v;
        ek       = N'(e);
        ki       = N'(k);
        hold     = h;
        clear    = c;
        @(posedge clk);
        model_edge();
        #1;
        check_eq("ik", longint'($signed(ik)), m_ik);
        check_eq("ik_valid", longint'(ik_valid), longint'(m_valid));
        check_eq("ik_sat", longint'(ik_sat), longint'(m_sat));
        if (ik_valid) vcnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic flush();
        step(0, 0, 0, 0, 1);
        idle(1);
    endtask

    function automatic int rnd18();
        logic [N-1:0] r;
        r = N'($urandom);
        return int'($signed(r));
    endfunction

    initial begin
        reset    = 1'b1;
        ek_valid = 1'b0;
        ek       = '0;
        ki       = '0;
        hold     = 1'b0;
        clear    = 1'b0;
        lim_hi   = N'(131071);
        lim_lo   = N'(-131072);
        idle(2);
        reset = 1'b0;
        idle(1);

        // Ramp
        vcnt = 0;
        for (int i = 0; i < 10; i++) step(1, 100, 256, 0, 0);
        idle(3);
        check_eq("ramp_pulses", vcnt, 10);
        check_eq("ramp_final_ik", longint'($signed(ik)), 1000);

        // Upper clamp, then back off
        flush();
        lim_hi = N'(500);
        for (int i = 0; i < 10; i++) step(1, 100, 256, 0, 0);
        idle(3);
        check_eq("clamp_ik", longint'($signed(ik)), 500);
        check_eq("clamp_sat", longint'(ik_sat), 1);
        step(1, -50, 256, 0, 0);
        idle(3);
        check_eq("unclamp_ik", longint'($signed(ik)), 450);
        check_eq("unclamp_sat", longint'(ik_sat), 0);
        lim_hi = N'(131071);

        // Floor rounding of negative values
        flush();
        step(1, -3, 128, 0, 0);
        idle(3);
        check_eq("round_neg1", longint'($signed(ik)), -2);
        step(1, -3, 128, 0, 0);
        idle(3);
        check_eq("round_neg2", longint'($signed(ik)), -3);

        // Hold keeps the integral but still pulses ik_valid
        flush();
        for (int i = 0; i < 3; i++) step(1, 100, 256, 0, 0);
        idle(2);
        vcnt = 0;
        for (int i = 0; i < 4; i++) step(1, 100, 256, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0);
        check_eq("hold_pulses", vcnt, 4);
        check_eq("hold_ik", longint'($signed(ik)), 300);
        step(1, 100, 256, 0, 0);
        idle(3);
        check_eq("after_hold_ik", longint'($signed(ik)), 400);

        // Clear with three samples in flight
        for (int i = 0; i < 3; i++) step(1, 77, 300, 0, 0);
        vcnt = 0;
        step(0, 0, 0, 0, 1);
        idle(3);
        check_eq("clear_pulses", vcnt, 0);
        check_eq("clear_ik", longint'($signed(ik)), 0);
        step(1, 77, 300, 0, 0);
        idle(3);
        check_eq("post_clear_ik", longint'($signed(ik)), (77 * 300) >>> FRAC);

        // Asynchronous reset between edges while streaming
        for (int i = 0; i < 6; i++) step(1, 1000, 200, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_ik", longint'($signed(ik)), 0);
        check_eq("async_rst_valid", longint'(ik_valid), 0);
        check_eq("async_rst_sat", longint'(ik_sat), 0);
        model_zero();
        sv[cyc] = 0;
        if (cyc >= 1) sv[cyc-1] = 0;
        step(1, 5, 5, 0, 0);
        step(1, 5, 5, 0, 0);
        reset = 1'b0;
        step(1, 1000, 256, 0, 0);
        step(0, 0, 0, 0, 0);
        check_eq("recover_early", longint'(ik_valid), 0);
        step(0, 0, 0, 0, 0);
        check_eq("recover_valid", longint'(ik_valid), 1);
        check_eq("recover_ik", longint'($signed(ik)), 1000);

        // Random streaming against the model
        for (int i = 0; i < 1500; i++) begin
            int e, k, hi, lo, tmp;
            if (i % 100 == 0) begin
                hi = int'($urandom_range(0, 131071));
                lo = -int'($urandom_range(0, 131072));
                if ($urandom_range(0, 7) == 0) begin
                    tmp = hi;
                    hi  = -lo - 1;
                    lo  = tmp;
                end
                lim_hi = N'(hi);
                lim_lo = N'(lo);
            end
            e = rnd18() >>> $urandom_range(0, 17);
            k = rnd18() >>> $urandom_range(0, 17);
            step($urandom_range(0, 3) != 0, e, k, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 39) == 0);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
